marquee_rect_disp: RTL and testbench
====================================

Name: marquee_rect_disp

Overview:
- Board-level 8-digit seven-segment animation block.
- Image mode plays a 19-frame rectangle animation from an internal ROM. Text mode scrolls an 8-digit hex constant.
- Frame rate is slow or fast, selected by a switch.
- Sits directly between the board switches and the multiplexed common-anode display.

Parameters:
- TEXT_VALUE, 32'h2025_1234, hex text shown in text mode (digit 7 = bits 31:28).
- SLOW_BIT, 25, divider bit that defines the slow frame period (2^(SLOW_BIT+1) cycles).
- FAST_BIT, 22, divider bit that defines the fast frame period.
- SCAN_BITS, 15, width of the per-digit scan counter (digit dwell = 2^SCAN_BITS cycles).

Ports:
- CLK100MHZ  in  1   100 MHz system clock; the only clock.
- CPU_RESETN  in  1   synchronous, active-low reset.
- SW  in  16  SW[0]: 1 = image mode, 0 = text mode. SW[15]: 1 = fast, 0 = slow. Other bits ignored.
- SEG  out  8   segments {DP,G,F,E,D,C,B,A}, active-low.
- AN  out  8   digit enables, active-low one-cold; AN[0] is the rightmost digit.

Behaviour:
- Divider
  - clkdiv is a free-running 32-bit counter; reset value 0.
  - Clk_CPU = clkdiv[SW[15] ? FAST_BIT : SLOW_BIT].
  - frame_tick = one-cycle pulse on the rising edge of Clk_CPU, detected with a registered previous value (no derived clocks).
  - A glitch caused by toggling SW[15] yields at most one extra tick. This is acceptable.
- Frame address
  - led_data_addr is 5 bits; reset value 0.
  - In image mode, each frame_tick increments it; 18 wraps to 0.
  - In text mode it holds its value.
- Text rotation
  - rot is 3 bits; reset value 0.
  - In text mode, each frame_tick increments it mod 8.
  - The display word is TEXT_VALUE rotated left by 4*rot bits. Each digit is hex-decoded (0-F standard glyphs, DP off).
  - rot holds in image mode.
- Scan
  - cnt is SCAN_BITS wide; it increments every cycle.
  - When cnt wraps to 0, seg7_addr (3 bits) increments mod 8.
  - Registered outputs: AN = ~(8'b1 << seg7_addr); SEG = glyph for digit seg7_addr of the current frame/text.
  - Output latency is one cycle after the seg7_addr/cnt update.
- Reset
  - cnt = 0, seg7_addr = 0, AN = 8'hFF, SEG = 8'hFF.
  - Reset asserted mid-frame returns everything to these values on the next edge.
- SW[0] is sampled every cycle; a mode change appears on the next registered output.
- Image ROM
  - 19 frames x 8 digits x 8 bits. Frames are given as active-high segment sets; they are inverted for output.
  - A rectangle of width w is centred. Its leftmost digit shows A,D,E,F; its rightmost digit shows A,B,C,D; interior digits show A,D.
  - Frames 0-3: grow, w = 2, 4, 6, 8.
  - Frames 4-6: blank, full w = 8, blank.
  - Frames 7-10: shrink, w = 8, 6, 4, 2.
  - Frame 11: blank.
  - Frames 12-18: one-digit box (A,B,C,D,E,F) on digit 7-j, j = 0..6.

Optional Feature:
- Macro MARQUEE_RECT_SIM_SPEED_EN.
- When defined, the effective SLOW_BIT = 13, FAST_BIT = 10 and SCAN_BITS = 4, overriding the parameters. This allows many frames within 50 ms of simulation.
- When undefined, the parameter values are used unchanged.

Decomposition:
- Package marquee_rect_pkg holds:
  - the frame count constant (19) and the last address (18);
  - segment bit constants;
  - the hex glyph table;
  - the 19x64-bit frame ROM constant.
- One sub-module, seg7_scan, contains cnt, seg7_addr, the AN/SEG registers and the 64-bit data input.
- The top level holds the divider, tick detector, led_data_addr, rot and data mux.

Test Plan:
- Reset held 100 ns, then released -> AN = FF and SEG = FF during reset. First digit enable afterwards is AN = 8'b1111_1110.
- Text mode, slow, SIM macro on -> AN cycles FE, FD, ..., 7F every 16 cycles. Digit 7 shows glyph '2' (SEG = 8'hA4) with rot = 0. After one frame_tick, digit 7 shows '0' (8'hC0).
- Image mode, slow -> led_data_addr goes 0, 1, 2, 3, 4 on five consecutive Clk_CPU rising edges. Frame 3 digit 7 = ~(A|D|E|F) = 8'hC6; digit 0 = ~(A|B|C|D) = 8'hF0.
- Image mode, fast, 25 ticks -> addresses 0..18 then 0..5; never reaches 19. Tick spacing is 2048 cycles.
- Toggle SW[0] to 0 mid-run -> led_data_addr freezes and rot advances. Toggle back -> led_data_addr resumes from the frozen value.
- Assert CPU_RESETN low at address 10 -> led_data_addr = 0 and rot = 0 one cycle later; AN = FF while reset is low.

Source files
------------

// File: rtl/marquee_rect_pkg.sv
// marquee_rect_pkg: frame constants, segment bits, hex glyphs and the rectangle animation ROM
// Frames are stored as active-high segment sets, one byte per digit (digit 7 in bits 63:56).
package marquee_rect_pkg;
  localparam int FRAME_COUNT = 19;
  localparam logic [4:0] LAST_ADDR = 5'd18;
  localparam logic [7:0] SEG_A = 8'h01, SEG_B = 8'h02, SEG_C = 8'h04, SEG_D = 8'h08;
  localparam logic [7:0] SEG_E = 8'h10, SEG_F = 8'h20, SEG_G = 8'h40, SEG_DP = 8'h80;
  localparam logic [7:0] RECT_LEFT = SEG_A | SEG_D | SEG_E | SEG_F;
  localparam logic [7:0] RECT_RIGHT = SEG_A | SEG_B | SEG_C | SEG_D;
  localparam logic [7:0] RECT_MID = SEG_A | SEG_D;
  localparam logic [7:0] RECT_BOX = RECT_LEFT | SEG_B | SEG_C;
  localparam logic [7:0] BLANK = 8'h00;
  localparam logic [63:0] RECT_W2 = {BLANK, BLANK, BLANK, RECT_LEFT, RECT_RIGHT, BLANK, BLANK, BLANK};
  localparam logic [63:0] RECT_W4 = {BLANK, BLANK, RECT_LEFT, RECT_MID, RECT_MID, RECT_RIGHT, BLANK, BLANK};
  localparam logic [63:0] RECT_W6 = {BLANK, RECT_LEFT, RECT_MID, RECT_MID, RECT_MID, RECT_MID, RECT_RIGHT, BLANK};
  localparam logic [63:0] RECT_W8 = {RECT_LEFT, RECT_MID, RECT_MID, RECT_MID, RECT_MID, RECT_MID, RECT_MID, RECT_RIGHT};
  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [63:0] FRAME_ROM [FRAME_COUNT] = '{
    RECT_W2, RECT_W4, RECT_W6, RECT_W8,
    64'h0, RECT_W8, 64'h0,
    RECT_W8, RECT_W6, RECT_W4, RECT_W2,
    64'h0,
    {RECT_BOX, 56'h0}, {8'h0, RECT_BOX, 48'h0}, {16'h0, RECT_BOX, 40'h0},
    {24'h0, RECT_BOX, 32'h0}, {32'h0, RECT_BOX, 24'h0}, {40'h0, RECT_BOX, 16'h0},
    {48'h0, RECT_BOX, 8'h0}
  };
endpackage

// File: rtl/marquee_rect_disp_seg7_scan.sv
// seg7_scan: multiplexes a 64-bit active-low glyph word onto an 8-digit common-anode display
// Ports: CLK100MHZ clock, CPU_RESETN sync active-low reset, data glyphs (digit d in bits 8d+7:8d),
// AN one-cold digit enables, SEG active-low segments; both outputs registered.
module seg7_scan #(
  parameter int SCAN_BITS = 15
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [63:0] data,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);
  logic [SCAN_BITS-1:0] cnt;
  logic [2:0] seg7_addr;
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      cnt <= '0;
      seg7_addr <= '0;
      AN <= 8'hFF;
      SEG <= 8'hFF;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) seg7_addr <= seg7_addr + 1'b1;
      AN <= ~(8'b1 << seg7_addr);
      SEG <= data[{seg7_addr, 3'b000} +: 8];
    end
  end
endmodule

// File: rtl/marquee_rect_disp.sv
// marquee_rect_disp: rectangle animation / scrolling hex text on an 8-digit seven-segment display
// Ports: CLK100MHZ clock, CPU_RESETN sync active-low reset, SW[0] image(1)/text(0), SW[15] fast(1)/slow(0),
// SEG active-low {DP,G,F,E,D,C,B,A}, AN active-low one-cold digit enables (AN[0] rightmost).
// Define MARQUEE_RECT_SIM_SPEED_EN to force SLOW_BIT=13, FAST_BIT=10, SCAN_BITS=4 for simulation.
module marquee_rect_disp
  import marquee_rect_pkg::*;
#(
  parameter logic [31:0] TEXT_VALUE = 32'h2025_1234,
  parameter int SLOW_BIT = 25,
  parameter int FAST_BIT = 22,
  parameter int SCAN_BITS = 15
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);
`ifdef MARQUEE_RECT_SIM_SPEED_EN
  localparam int SB = 13, FB = 10, SC = 4;
`else
  localparam int SB = SLOW_BIT, FB = FAST_BIT, SC = SCAN_BITS;
`endif
  logic [31:0] clkdiv;
  logic clk_cpu, clk_cpu_q, frame_tick;
  logic [4:0] led_data_addr;
  logic [2:0] rot;
  logic [31:0] text_word;
  logic [63:0] text_data, disp_data;
  assign clk_cpu = SW[15] ? clkdiv[FB] : clkdiv[SB];
  assign frame_tick = clk_cpu & ~clk_cpu_q;
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      clkdiv <= '0;
      clk_cpu_q <= 1'b0;
      led_data_addr <= '0;
      rot <= '0;
    end else begin
      clkdiv <= clkdiv + 1'b1;
      clk_cpu_q <= clk_cpu;
      if (frame_tick && SW[0]) led_data_addr <= (led_data_addr == LAST_ADDR) ? 5'd0 : led_data_addr + 5'd1;
      if (frame_tick && !SW[0]) rot <= rot + 1'b1;
    end
  end
  // Rotate left by 4*rot: take a 32-bit window out of the doubled word.
  assign text_word = 32'({TEXT_VALUE, TEXT_VALUE} >> (6'd32 - {1'b0, rot, 2'b00}));
  always_comb begin
    text_data = '0;
    for (int i = 0; i < 8; i++) text_data[8*i +: 8] = HEX_GLYPH[text_word[4*i +: 4]];
  end
  assign disp_data = SW[0] ? ~FRAME_ROM[led_data_addr] : text_data;
  seg7_scan #(.SCAN_BITS(SC)) u_scan (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .data      (disp_data),
    .AN        (AN),
    .SEG       (SEG)
  );
endmodule

// File: tb/tb_marquee_rect_disp.sv
// tb_marquee_rect_disp: randomized scoreboard bench comparing AN/SEG every cycle against a behavioural model
module tb_marquee_rect_disp;
`ifdef MARQUEE_RECT_SIM_SPEED_EN
  localparam int SB = 13, FB = 10, SC = 4, NT = 1, NI = 1, NF = 8, NR = 3;
`else
  localparam int SB = 8, FB = 6, SC = 3, NT = 10, NI = 6, NF = 25, NR = 24;
`endif
  localparam logic [31:0] TV = 32'h2025_1234;
  logic CLK100MHZ = 1'b0;
  logic CPU_RESETN = 1'b0;
  logic [15:0] SW = 16'h0;
  logic [7:0] SEG, AN;
  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  longint n = 0;
  int addr = 0, rot = 0;
  bit sel_last = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;
  marquee_rect_disp #(.TEXT_VALUE(TV), .SLOW_BIT(8), .FAST_BIT(6), .SCAN_BITS(3)) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .SW        (SW),
    .SEG       (SEG),
    .AN        (AN)
  );
  function automatic logic [7:0] hex_hi(int v);
    case (v)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  10: return 8'h77; 11: return 8'h7C;
      12: return 8'h39; 13: return 8'h5E; 14: return 8'h79; default: return 8'h71;
    endcase
  endfunction
  // Rectangle of width w centred across digits 7..0; boxes sweep right from digit 7.
  function automatic logic [7:0] frame_hi(int f, int d);
    int w, lo, hi;
    if (f >= 12) return (d == 7 - (f - 12)) ? 8'h3F : 8'h00;
    w = (f <= 3) ? 2 * (f + 1) : (f >= 7 && f <= 10) ? 2 * (11 - f) : (f == 5) ? 8 : 0;
    if (w == 0) return 8'h00;
    lo = 4 - w / 2;
    hi = 3 + w / 2;
    if (d == hi) return 8'h39;
    if (d == lo) return 8'h0F;
    return (d > lo && d < hi) ? 8'h09 : 8'h00;
  endfunction
  function automatic logic [7:0] exp_seg(bit img, int a, int r, int d);
    if (img) return ~frame_hi(a, d);
    return ~hex_hi(int'((TV >> (4 * ((d - r + 8) % 8))) & 32'hF));
  endfunction
  initial forever begin
    int d, sb_now, sb_prev;
    bit b_now, b_prev;
    @(posedge CLK100MHZ);
    if (!CPU_RESETN) begin
      exp_q.push_back(16'hFFFF);
      n = 0;
      addr = 0;
      rot = 0;
    end else begin
      d = int'((n >> SC) % 8);
      exp_q.push_back({~(8'd1 << d), exp_seg(SW[0], addr, rot, d)});
      sb_now = SW[15] ? FB : SB;
      sb_prev = sel_last ? FB : SB;
      b_now = ((n >> sb_now) & 1) != 0;
      b_prev = (n > 0) && (((n - 1) >> sb_prev) & 1) != 0;
      if (b_now && !b_prev) begin
        if (SW[0]) addr = (addr + 1) % 19;
        else rot = (rot + 1) % 8;
      end
      n = n + 1;
    end
    sel_last = SW[15];
  end
  initial forever begin
    logic [15:0] e;
    @(negedge CLK100MHZ);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({AN, SEG} !== e) begin
        failures++;
        if (failures <= 20) $display("FAIL scan t=%0t an=%h seg=%h expected an=%h seg=%h", $time, AN, SEG, e[15:8], e[7:0]);
      end
    end
  end
  task automatic cyc(int k);
    repeat (k) @(posedge CLK100MHZ);
    #1;
  endtask
  initial begin
    cyc(10);
    CPU_RESETN = 1'b1;
    cyc(NT * (2 ** (SB + 1)));
    SW = 16'h0001;
    cyc(NI * (2 ** (SB + 1)));
    SW = 16'h8001;
    cyc(NF * (2 ** (FB + 1)));
    SW = 16'h8000;
    cyc(3 * (2 ** (FB + 1)));
    SW = 16'h8001;
    cyc(2 * (2 ** (FB + 1)) + 37);
    CPU_RESETN = 1'b0;
    cyc(2);
    CPU_RESETN = 1'b1;
    repeat (NR) begin
      SW = 16'($urandom);
      cyc($urandom_range(50, 2 ** (FB + 3)));
      if ($urandom_range(0, 5) == 0) begin
        CPU_RESETN = 1'b0;
        cyc($urandom_range(1, 3));
        CPU_RESETN = 1'b1;
      end
    end
    CPU_RESETN = 1'b0;
    cyc(4);
    if (checks < 1000) begin
      failures++;
      $display("FAIL check_count got=%0d required_at_least=1000", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
